// File: rtl/icache_refill_axi_master_pkg.sv
// Shared types and constants for the instruction-cache refill AXI read master.
package icache_refill_axi_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Number of byte-offset bits inside one cache line of line_beats 64-bit beats.
  function automatic int line_offset_bits(input int line_beats);
    return $clog2(8 * line_beats);
  endfunction

endpackage

// File: rtl/icache_refill_axi_master_if.sv
// Cache-side miss/refill handshakes plus the AXI AR/R channels of the refill master.
interface icache_refill_axi_master_if #(
  parameter int LINE_BEATS = 4
);
  // Every channel is valid/ready: a transfer happens on a rising clk edge where
  // both are high; once valid rises, it and its payload stay stable until that edge.
  logic                       miss_valid;
  logic                       miss_ready;
  logic [31:0]                miss_addr;

  logic                       refill_valid;
  logic                       refill_ready;
  logic [31:0]                refill_addr;
  logic [64*LINE_BEATS-1:0]   refill_data;
  logic                       refill_err;

  logic                       arvalid;
  logic                       arready;
  logic [31:0]                araddr;
  logic [3:0]                 arid;
  logic [7:0]                 arlen;
  logic [2:0]                 arsize;
  logic [1:0]                 arburst;

  logic                       rready;
  logic                       rvalid;
  logic [1:0]                 rresp;
  logic [63:0]                rdata;
  logic                       rlast;
  logic [3:0]                 rid;

  modport master (
    input  miss_valid, miss_addr, refill_ready, arready,
           rvalid, rresp, rdata, rlast, rid,
    output miss_ready, refill_valid, refill_addr, refill_data, refill_err,
           arvalid, araddr, arid, arlen, arsize, arburst, rready
  );

  modport slave (
    output miss_valid, miss_addr, refill_ready, arready,
           rvalid, rresp, rdata, rlast, rid,
    input  miss_ready, refill_valid, refill_addr, refill_data, refill_err,
           arvalid, araddr, arid, arlen, arsize, arburst, rready
  );

endinterface

// File: rtl/icache_refill_axi_master.sv
// Issues one INCR read burst per I-cache miss, gathers the beats into a line
// buffer and returns the whole line with a sticky error flag.
module icache_refill_axi_master
  import icache_refill_axi_master_pkg::*;
#(
  parameter int         LINE_BEATS = 4,
  parameter logic [3:0] AXI_ID     = 4'h0
) (
  input  logic                              clk,
  input  logic                              rst,
  icache_refill_axi_master_if.master        bus,
  output state_t                            dbg_state
);

  localparam int OFF_BITS = line_offset_bits(LINE_BEATS);
  localparam int IW       = $clog2(LINE_BEATS);
  localparam int CW       = IW + 1;
  localparam logic [CW-1:0] BEATS_C = CW'(LINE_BEATS);
  localparam logic [CW-1:0] LAST_C  = CW'(LINE_BEATS - 1);

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic                     err;
  logic [31:0]              line_addr;
  logic [63:0]              line_buf [LINE_BEATS];
  logic [64*LINE_BEATS-1:0] line_flat;

  logic miss_ready_q;
  logic arvalid_q;
  logic rready_q;
  logic refill_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      err            <= 1'b0;
      line_addr      <= '0;
      miss_ready_q   <= 1'b1;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      refill_valid_q <= 1'b0;
      for (int i = 0; i < LINE_BEATS; i++) line_buf[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.miss_valid) begin
            line_addr    <= {bus.miss_addr[31:OFF_BITS], {OFF_BITS{1'b0}}};
            cnt          <= '0;
            err          <= 1'b0;
            miss_ready_q <= 1'b0;
            arvalid_q    <= 1'b1;
            state        <= ST_AR;
          end
        end
        ST_AR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_R;
          end
        end
        ST_R: begin
          if (bus.rvalid) begin
            // Beats past the line are swallowed so the burst can still finish on rlast.
            if (cnt < BEATS_C) begin
              line_buf[cnt[IW-1:0]] <= bus.rdata;
              cnt                   <= cnt + 1'b1;
            end else begin
              err <= 1'b1;
            end
            if ((bus.rresp != RESP_OKAY) || (bus.rid != AXI_ID) ||
                (bus.rlast && (cnt != LAST_C))) begin
              err <= 1'b1;
            end
            if (bus.rlast) begin
              rready_q       <= 1'b0;
              refill_valid_q <= 1'b1;
              state          <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (bus.refill_ready) begin
            refill_valid_q <= 1'b0;
            miss_ready_q   <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    line_flat = '0;
    for (int i = 0; i < LINE_BEATS; i++) line_flat[64*i +: 64] = line_buf[i];
  end

  assign bus.miss_ready   = miss_ready_q;
  assign bus.refill_valid = refill_valid_q;
  assign bus.refill_addr  = line_addr;
  assign bus.refill_data  = line_flat;
  assign bus.refill_err   = err;
  assign bus.arvalid      = arvalid_q;
  assign bus.araddr       = line_addr;
  assign bus.arid         = AXI_ID;
  assign bus.arlen        = 8'(LINE_BEATS - 1);
  assign bus.arsize       = SIZE_8B;
  assign bus.arburst      = BURST_INCR;
  assign bus.rready       = rready_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_icache_refill_axi_master.sv
// Directed bench for icache_refill_axi_master (LINE_BEATS=4): drivers push expected
// AR addresses and refill lines into queues, a negedge monitor pops and compares.
module tb_icache_refill_axi_master;
  import icache_refill_axi_master_pkg::*;

  localparam int EW = 1 + 32 + 256;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  icache_refill_axi_master_if #(.LINE_BEATS(4)) bus ();

  icache_refill_axi_master #(.LINE_BEATS(4), .AXI_ID(4'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int tag      = 0;
  logic [EW-1:0] exp_q [$];
  logic [31:0]   ar_q  [$];
  logic [63:0]   mdl_buf [4];
  logic          rv_pend = 1'b0;

  function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] beat_data(input int t, input int i);
    return {16'hBEEF, 8'(t), 8'(i), 32'hCAFE_0000 + 32'(t * 16 + i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic issue_miss(input logic [31:0] maddr);
    bus.miss_valid = 1'b1;
    bus.miss_addr  = maddr;
    tick();
    bus.miss_valid = 1'b0;
    bus.miss_addr  = 32'h0;
  endtask

  task automatic accept_ar(input int ar_wait);
    check("arvalid_c1", 256'(bus.arvalid), 256'(1));
    bus.arready = 1'b0;
    for (int w = 0; w < ar_wait; w++) begin
      tick();
      check("arvalid_hold", 256'(bus.arvalid), 256'(1));
    end
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
  endtask

  task automatic send_beats(input int nb, input int bad_resp, input int bad_id, input int gap);
    for (int i = 0; i < nb; i++) begin
      for (int g = 0; (i > 0) && (g < gap); g++) begin
        bus.rvalid = 1'b0;
        tick();
      end
      check("rready_r", 256'(bus.rready), 256'(1));
      bus.rvalid = 1'b1;
      bus.rdata  = beat_data(tag, i);
      bus.rresp  = (i == bad_resp) ? 2'b10 : 2'b00;
      bus.rid    = (i == bad_id) ? 4'h5 : 4'h0;
      bus.rlast  = (i == nb - 1);
      tick();
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
    bus.rid    = 4'h0;
  endtask

  task automatic run_refill(input logic [31:0] maddr, input logic [31:0] laddr, input int nb,
                            input int bad_resp, input int bad_id, input int ar_wait,
                            input int gap, input int rr_wait);
    logic          err;
    logic [255:0]  line;
    tag++;
    err = (nb != 4) || (bad_resp >= 0) || (bad_id >= 0);
    for (int i = 0; i < nb && i < 4; i++) mdl_buf[i] = beat_data(tag, i);
    for (int i = 0; i < 4; i++) line[64*i +: 64] = mdl_buf[i];
    exp_q.push_back({err, laddr, line});
    ar_q.push_back(laddr);
    issue_miss(maddr);
    accept_ar(ar_wait);
    send_beats(nb, bad_resp, bad_id, gap);
    check("refill_valid_lat", 256'(bus.refill_valid), 256'(1));
    for (int w = 0; w < rr_wait; w++) tick();
    bus.refill_ready = 1'b1;
    tick();
    bus.refill_ready = 1'b0;
    check("miss_ready_idle", 256'(bus.miss_ready), 256'(1));
    check("state_idle", 256'(dbg_state), 256'(ST_IDLE));
  endtask

  task automatic check_reset_values();
    check("rst_miss_ready",   256'(bus.miss_ready),   256'(1));
    check("rst_refill_valid", 256'(bus.refill_valid), 256'(0));
    check("rst_refill_err",   256'(bus.refill_err),   256'(0));
    check("rst_refill_addr",  256'(bus.refill_addr),  256'(0));
    check("rst_refill_data",  bus.refill_data,        256'(0));
    check("rst_arvalid",      256'(bus.arvalid),      256'(0));
    check("rst_araddr",       256'(bus.araddr),       256'(0));
    check("rst_rready",       256'(bus.rready),       256'(0));
    check("rst_state",        256'(dbg_state),        256'(ST_IDLE));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      rv_pend = 1'b0;
    end else begin
      if (bus.arvalid) begin
        if (ar_q.size() == 0) begin
          check("ar_unexpected", 256'(bus.arvalid), 256'(0));
        end else begin
          check("araddr",  256'(bus.araddr),  256'(ar_q[0]));
          check("arlen",   256'(bus.arlen),   256'(3));
          check("arsize",  256'(bus.arsize),  256'(3));
          check("arburst", 256'(bus.arburst), 256'(1));
          check("arid",    256'(bus.arid),    256'(0));
          if (bus.arready) void'(ar_q.pop_front());
        end
      end
      if (bus.refill_valid) begin
        if (exp_q.size() == 0) begin
          check("refill_unexpected", 256'(bus.refill_valid), 256'(0));
        end else begin
          check("refill_err",  256'(bus.refill_err),  256'(exp_q[0][288]));
          check("refill_addr", 256'(bus.refill_addr), 256'(exp_q[0][287:256]));
          check("refill_data", bus.refill_data,       exp_q[0][255:0]);
          if (bus.refill_ready) void'(exp_q.pop_front());
        end
      end
      if (rv_pend) check("refill_valid_held", 256'(bus.refill_valid), 256'(1));
      rv_pend = bus.refill_valid && !bus.refill_ready;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus.miss_valid   = 1'b0;
    bus.miss_addr    = 32'h0;
    bus.refill_ready = 1'b0;
    bus.arready      = 1'b0;
    bus.rvalid       = 1'b0;
    bus.rresp        = 2'b00;
    bus.rdata        = 64'h0;
    bus.rlast        = 1'b0;
    bus.rid          = 4'h0;
    for (int i = 0; i < 4; i++) mdl_buf[i] = 64'h0;
    repeat (3) tick();
    check_reset_values();
    rst = 1'b0;

    // zero-wait refill: refill_valid lands in cycle 6
    run_refill(32'h8000_0014, 32'h8000_0000, 4, -1, -1, 0, 0, 0);
    // arready withheld 5 cycles
    run_refill(32'h1234_567F, 32'h1234_5660, 4, -1, -1, 5, 0, 0);
    // rvalid gaps, refill_ready withheld 3 cycles
    run_refill(32'h0000_1008, 32'h0000_1000, 4, -1, -1, 0, 2, 3);
    // SLVERR on beat 2
    run_refill(32'hA000_0040, 32'hA000_0040, 4, 2, -1, 0, 0, 1);
    // early rlast on beat 1; slots 2,3 keep the previous line
    run_refill(32'h4000_003C, 32'h4000_0020, 2, -1, -1, 0, 0, 0);
    // six beats, rlast on beat 5
    run_refill(32'h5555_5550, 32'h5555_5540, 6, -1, -1, 1, 1, 0);
    // wrong rid on beat 0
    run_refill(32'h0BAD_0001, 32'h0BAD_0000, 4, -1, 0, 0, 0, 0);

    // reset in R on beat 2
    tag++;
    ar_q.push_back(32'h7000_0000);
    issue_miss(32'h7000_0008);
    accept_ar(0);
    for (int i = 0; i < 2; i++) begin
      bus.rvalid = 1'b1;
      bus.rdata  = beat_data(tag, i);
      tick();
    end
    bus.rvalid = 1'b1;
    bus.rdata  = beat_data(tag, 2);
    rst        = 1'b1;
    tick();
    bus.rvalid = 1'b0;
    check_reset_values();
    for (int i = 0; i < 4; i++) mdl_buf[i] = 64'h0;
    rst = 1'b0;
    tick();
    run_refill(32'h7000_0018, 32'h7000_0000, 4, -1, -1, 0, 0, 0);

    repeat (3) tick();
    check("exp_q_drained", 256'(exp_q.size()), 256'(0));
    check("ar_q_drained",  256'(ar_q.size()),  256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
